// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - serialises fetch and data accesses onto one single-ported synchronous memory
// Optional fetch starvation guard: define PIPE_MEM_ARB_STARVE_GUARD_EN.
module pipe_mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            own_if_q, own_d_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   if_rdata_q, d_rdata_q;
  logic            any_req, grant_data, force_fetch, grant_now;

  assign any_req   = if_req | d_req;
  assign grant_now = (state_q == S_IDLE) & any_req;
  assign grant_data = d_req & ~force_fetch;

`ifdef PIPE_MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_fetch = if_req & d_req & (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (grant_now) begin
      if (!grant_data)
        starve_d = 4'd0;
      else if (if_req)
        starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`else
  // Without the guard the limit has no effect; data always wins.
  assign force_fetch = 1'b0 & (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (cnt_q == 4'd1) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    case (state_q)
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      S_DONE: begin
        if_valid = own_if_q;
        d_valid  = own_d_q;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at grant so the pipeline may change them freely afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      own_if_q   <= 1'b0;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_now) begin
        own_d_q  <= grant_data;
        own_if_q <= ~grant_data;
        we_q     <= grant_data & d_we;
        addr_q   <= grant_data ? d_addr : if_addr;
        if (grant_data) wdata_q <= d_wdata;
      end
      if (state_q == S_ACCESS)
        cnt_q <= 4'(MEM_LAT);
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q - 4'd1;
      if (state_q == S_WAIT && cnt_q == 4'd1) begin
        if (own_if_q)          if_rdata_q <= mem_rdata;
        if (own_d_q && !we_q)  d_rdata_q  <= mem_rdata;
      end
      if (state_q == S_DONE) begin
        own_if_q <= 1'b0;
        own_d_q  <= 1'b0;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - directed checks of pipe_mem_arbiter at MEM_LAT 1, 3 and 4
// Unwritten memory words read as addr + 0x95.
module tb_pipe_mem_arbiter;

  localparam int NI = 3;
  localparam int LAT_TAB [NI] = '{1, 3, 4};

  logic       clock, reset;
  logic       if_req   [NI];
  logic [7:0] if_addr  [NI];
  logic [7:0] if_rdata [NI];
  logic       if_valid [NI];
  logic       d_req    [NI];
  logic       d_we     [NI];
  logic [7:0] d_addr   [NI];
  logic [7:0] d_wdata  [NI];
  logic [7:0] d_rdata  [NI];
  logic       d_valid  [NI];
  logic       mem_en   [NI];
  logic       mem_we   [NI];
  logic [7:0] mem_addr [NI];
  logic [7:0] mem_wdata[NI];
  logic [7:0] mem_rdata[NI];
  logic       stall    [NI];

  int n_vec = 0;
  int n_miss = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = LAT_TAB[g];
    logic [7:0]   mem [256];
    logic [255:0] written;
    logic [7:0]   rpipe [L];
    logic [7:0]   rd_word;

    assign rd_word = written[mem_addr[g]] ? mem[mem_addr[g]] : mem_addr[g] + 8'h95;

    always @(posedge clock) begin
      if (reset)
        written <= '0;
      else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]]     <= mem_wdata[g];
        written[mem_addr[g]] <= 1'b1;
      end
      if (mem_en[g]) rpipe[0] <= rd_word;
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    assign mem_rdata[g] = rpipe[L-1];

    pipe_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(L), .STARVE_LIMIT(2)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_valid (if_valid[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_valid  (d_valid[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stall    (stall[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Issues one request on instance k, returns the cycle of its valid (cycle 0 = request visible).
  task automatic do_access(input int k, input bit is_d, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input bit chg,
                           output int lat, output int en_cnt, output int en_cyc,
                           output logic [7:0] en_addr, output logic en_we, output logic [7:0] en_wdata);
    logic v;
    lat = -1; en_cnt = 0; en_cyc = -1; en_addr = '0; en_we = 1'b0; en_wdata = '0;
    cyc();
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (int c = 0; c < 24; c++) begin
      if (c > 0) cyc();
      if (chg && c == 2) begin
        if (is_d) d_addr[k] = addr + 8'd1;
        else      if_addr[k] = addr + 8'd1;
      end
      #2;
      if (mem_en[k]) begin
        en_cnt++; en_cyc = c; en_addr = mem_addr[k]; en_we = mem_we[k]; en_wdata = mem_wdata[k];
      end
      v = is_d ? d_valid[k] : if_valid[k];
      check($sformatf("stall_i%0d_c%0d", k, c), 32'(stall[k]), 32'(!v));
      if (v) begin
        lat = c;
        break;
      end
    end
    cyc();
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    #2;
    check("valid_one_shot", 32'(is_d ? d_valid[k] : if_valid[k]), 0);
  endtask

  int lat, en_cnt, en_cyc, dv, iv, n_en, n_ord;
  int en_c [2];
  int ord [4];
  int exp_ord [4];
  logic [7:0] ea, ewd;
  logic ewe;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) @(posedge clock);
    #3;
    for (int k = 0; k < NI; k++) begin
      check("rst_mem_en",   32'(mem_en[k]), 0);
      check("rst_mem_addr", 32'(mem_addr[k]), 0);
      check("rst_if_valid", 32'(if_valid[k]), 0);
      check("rst_d_valid",  32'(d_valid[k]), 0);
      check("rst_stall",    32'(stall[k]), 0);
      check("rst_if_rdata", 32'(if_rdata[k]), 0);
    end
    cyc();
    reset = 1'b0;

    // Single fetch, MEM_LAT=1
    do_access(0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t1_lat", lat, 3);
    check("t1_en_cyc", en_cyc, 1);
    check("t1_en_cnt", en_cnt, 1);
    check("t1_mem_addr", 32'(ea), 32'h10);
    check("t1_mem_we", 32'(ewe), 0);
    check("t1_if_rdata", 32'(if_rdata[0]), 32'hA5);

    // Store then load, MEM_LAT=3
    do_access(1, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t2_st_lat", lat, 5);
    check("t2_st_we", 32'(ewe), 1);
    check("t2_st_wdata", 32'(ewd), 32'h3C);
    check("t2_st_addr", 32'(ea), 32'h20);
    check("t2_st_rdata_kept", 32'(d_rdata[1]), 0);
    do_access(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t2_ld_lat", lat, 5);
    check("t2_ld_we", 32'(ewe), 0);
    check("t2_ld_rdata", 32'(d_rdata[1]), 32'h3C);
    do_access(1, 1'b1, 1'b1, 8'h21, 8'h5A, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t2_st2_lat", lat, 5);
    check("t2_st2_rdata_kept", 32'(d_rdata[1]), 32'h3C);

    // Simultaneous requests, MEM_LAT=1: data first, one idle cycle, then fetch
    cyc();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h30;
    if_req[0] = 1'b1; if_addr[0] = 8'h10;
    dv = -1; iv = -1; n_en = 0; en_c = '{-1, -1};
    for (int c = 0; c < 24; c++) begin
      if (c > 0) cyc();
      if (dv >= 0) d_req[0] = 1'b0;
      if (iv >= 0) if_req[0] = 1'b0;
      if (dv >= 0 && iv >= 0) break;
      #2;
      if (mem_en[0]) begin
        if (n_en < 2) en_c[n_en] = c;
        n_en++;
      end
      if (d_valid[0])  dv = c;
      if (if_valid[0]) iv = c;
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    check("t3_d_valid_cyc", dv, 3);
    check("t3_if_valid_cyc", iv, 7);
    check("t3_en_count", n_en, 2);
    check("t3_en0_cyc", en_c[0], 1);
    check("t3_en1_cyc", en_c[1], 5);
    check("t3_d_rdata", 32'(d_rdata[0]), 32'hC5);
    check("t3_if_rdata", 32'(if_rdata[0]), 32'hA5);

    // Address change after grant, MEM_LAT=3
    do_access(1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t4_lat", lat, 5);
    check("t4_en_addr", 32'(ea), 32'h10);
    check("t4_addr_hold", 32'(mem_addr[1]), 32'h10);
    check("t4_if_rdata", 32'(if_rdata[1]), 32'hA5);

    // Reset mid-WAIT, MEM_LAT=4
    do_access(2, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t5_pre_lat", lat, 6);
    check("t5_pre_rdata", 32'(if_rdata[2]), 32'hA5);
    cyc();
    if_req[2] = 1'b1; if_addr[2] = 8'h12;
    cyc();
    #2;
    check("t5_access_addr", 32'(mem_addr[2]), 32'h12);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    if_req[2] = 1'b0;
    #2;
    check("t5_rst_mem_en", 32'(mem_en[2]), 0);
    check("t5_rst_mem_addr", 32'(mem_addr[2]), 0);
    check("t5_rst_if_rdata", 32'(if_rdata[2]), 0);
    check("t5_rst_d_rdata1", 32'(d_rdata[1]), 0);
    check("t5_rst_stall", 32'(stall[2]), 0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      #2;
      check("t5_no_valid", 32'(if_valid[2]), 0);
      check("t5_no_en", 32'(mem_en[2]), 0);
    end
    cyc();
    reset = 1'b0;
    do_access(2, 1'b0, 1'b0, 8'h13, 8'h00, 1'b0, lat, en_cnt, en_cyc, ea, ewe, ewd);
    check("t5_post_lat", lat, 6);
    check("t5_post_rdata", 32'(if_rdata[2]), 32'hA8);

    // Starvation: data held continuously, fetch held
`ifdef PIPE_MEM_ARB_STARVE_GUARD_EN
    exp_ord = '{0, 0, 1, 0};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    cyc();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h40;
    if_req[0] = 1'b1; if_addr[0] = 8'h10;
    n_ord = 0; ord = '{7, 7, 7, 7};
    for (int c = 0; c < 40 && n_ord < 4; c++) begin
      if (c > 0) cyc();
      #2;
      if (d_valid[0]) begin
        ord[n_ord] = 0; n_ord++;
      end else if (if_valid[0]) begin
        ord[n_ord] = 1; n_ord++;
      end
    end
    cyc();
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("t6_order%0d", i), ord[i], exp_ord[i]);

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
